// File: rtl/icache_data_array.sv
// Instruction cache data store with registered fetch output and saturating
// fetch/miss performance counters. Array is unreset; fills survive reset.
module icache_data_array #(
    parameter int DATA_WIDTH  = 8,
    parameter int LINE_BITS   = 2,
    parameter int OFFSET_BITS = 3,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   sync_reset_n,
    input  logic                   cache_wren,
    input  logic [LINE_BITS-1:0]   cache_wrline,
    input  logic [OFFSET_BITS-1:0] cache_wroffset,
    input  logic [DATA_WIDTH-1:0]  rom_data,
    input  logic [LINE_BITS-1:0]   cache_rdline,
    input  logic [OFFSET_BITS-1:0] cache_rdoffset,
    input  logic                   hold_out,
    output logic [DATA_WIDTH-1:0]  instr_out,
    output logic                   instr_valid,
    output logic [CNT_WIDTH-1:0]   fetch_count,
    output logic [CNT_WIDTH-1:0]   miss_count
);

    localparam int ADDR_BITS = LINE_BITS + OFFSET_BITS;
    localparam int DEPTH     = 1 << ADDR_BITS;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_BITS-1:0]  wr_addr;
    logic [ADDR_BITS-1:0]  rd_addr;
    logic                  bypass;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  hold_out_d;
    logic                  fetch_inc;
    logic                  miss_inc;

    assign wr_addr = {cache_wrline, cache_wroffset};
    assign rd_addr = {cache_rdline, cache_rdoffset};

    // Forward the word being filled so the last fill cycle can also be a fetch.
    always_comb begin
        bypass  = cache_wren && (wr_addr == rd_addr);
        rd_data = bypass ? rom_data : mem[rd_addr];
    end

    always_ff @(posedge clk) begin
        if (cache_wren)
            mem[wr_addr] <= rom_data;
    end

    assign fetch_inc = !hold_out && (fetch_count != {CNT_WIDTH{1'b1}});
    assign miss_inc  = hold_out && !hold_out_d && (miss_count != {CNT_WIDTH{1'b1}});

    always_ff @(posedge clk) begin
        if (!sync_reset_n) begin
            instr_out   <= '0;
            instr_valid <= 1'b0;
            fetch_count <= '0;
            miss_count  <= '0;
            hold_out_d  <= 1'b0;
        end else begin
            hold_out_d <= hold_out;
            if (!hold_out) begin
                instr_out   <= rd_data;
                instr_valid <= 1'b1;
            end else begin
                instr_valid <= 1'b0;
            end
            if (fetch_inc)
                fetch_count <= fetch_count + 1'b1;
            if (miss_inc)
                miss_count <= miss_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_icache_data_array.sv
// Directed-vector bench for icache_data_array: reset, fill, bypass, stall,
// reset during fill and counter saturation.
module tb_icache_data_array;

    logic        clk = 1'b0;
    logic        sync_reset_n;
    logic        cache_wren;
    logic [1:0]  cache_wrline;
    logic [2:0]  cache_wroffset;
    logic [7:0]  rom_data;
    logic [1:0]  cache_rdline;
    logic [2:0]  cache_rdoffset;
    logic        hold_out;
    logic [7:0]  instr_out;
    logic        instr_valid;
    logic [15:0] fetch_count;
    logic [15:0] miss_count;

    int checks   = 0;
    int failures = 0;

    icache_data_array dut (
        .clk            (clk),
        .sync_reset_n   (sync_reset_n),
        .cache_wren     (cache_wren),
        .cache_wrline   (cache_wrline),
        .cache_wroffset (cache_wroffset),
        .rom_data       (rom_data),
        .cache_rdline   (cache_rdline),
        .cache_rdoffset (cache_rdoffset),
        .hold_out       (hold_out),
        .instr_out      (instr_out),
        .instr_valid    (instr_valid),
        .fetch_count    (fetch_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        sync_reset_n   = 1'b0;
        cache_wren     = 1'b0;
        cache_wrline   = '0;
        cache_wroffset = '0;
        rom_data       = '0;
        cache_rdline   = '0;
        cache_rdoffset = '0;
        hold_out       = 1'b0;

        // Reset held two cycles
        tick();
        tick();
        chk_eq("rst_instr", instr_out, 0);
        chk_eq("rst_valid", instr_valid, 0);
        chk_eq("rst_fetch", fetch_count, 0);
        chk_eq("rst_miss", miss_count, 0);

        sync_reset_n = 1'b1;
        tick();
        chk_eq("post_rst_valid", instr_valid, 1);
        chk_eq("post_rst_fetch", fetch_count, 1);

        // Fill line 1 while stalled
        hold_out   = 1'b1;
        cache_wren = 1'b1;
        cache_wrline = 2'd1;
        for (int i = 0; i < 8; i++) begin
            cache_wroffset = 3'(i);
            rom_data       = 8'h10 + 8'(i);
            tick();
            chk_eq($sformatf("fill_valid%0d", i), instr_valid, 0);
        end
        chk_eq("fill_miss", miss_count, 1);
        chk_eq("fill_fetch", fetch_count, 1);

        cache_wren     = 1'b0;
        hold_out       = 1'b0;
        cache_rdline   = 2'd1;
        cache_rdoffset = 3'd5;
        tick();
        chk_eq("rd15_instr", instr_out, 8'h15);
        chk_eq("rd15_valid", instr_valid, 1);
        chk_eq("rd15_fetch", fetch_count, 2);

        // Preload line2/off6 while fetching a different address
        cache_wren     = 1'b1;
        cache_wrline   = 2'd2;
        cache_wroffset = 3'd6;
        rom_data       = 8'h3C;
        tick();
        chk_eq("wr_other_instr", instr_out, 8'h15);

        // Bypass: write and read same address
        cache_wroffset = 3'd7;
        rom_data       = 8'hA5;
        cache_rdline   = 2'd2;
        cache_rdoffset = 3'd7;
        tick();
        chk_eq("bypass_instr", instr_out, 8'hA5);

        // Write to off7 while reading off6: no bypass
        cache_rdoffset = 3'd6;
        tick();
        chk_eq("nobypass_instr", instr_out, 8'h3C);
        chk_eq("nobypass_fetch", fetch_count, 5);

        // Stall hold
        cache_wren     = 1'b0;
        cache_rdline   = 2'd1;
        cache_rdoffset = 3'd5;
        tick();
        chk_eq("pre_stall_instr", instr_out, 8'h15);
        hold_out = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cache_rdline   = 2'd2;
            cache_rdoffset = 3'(5 + i);
            tick();
            chk_eq($sformatf("stall_instr%0d", i), instr_out, 8'h15);
            chk_eq($sformatf("stall_valid%0d", i), instr_valid, 0);
        end
        chk_eq("stall_miss", miss_count, 2);
        chk_eq("stall_fetch", fetch_count, 6);

        // Fill line 3, reset asserted from word 4 on while writes continue
        cache_wren   = 1'b1;
        cache_wrline = 2'd3;
        for (int i = 0; i < 8; i++) begin
            if (i == 4) sync_reset_n = 1'b0;
            cache_wroffset = 3'(i);
            rom_data       = 8'hC0 + 8'(i);
            tick();
        end
        chk_eq("midrst_instr", instr_out, 0);
        chk_eq("midrst_valid", instr_valid, 0);
        chk_eq("midrst_fetch", fetch_count, 0);
        chk_eq("midrst_miss", miss_count, 0);

        cache_wren   = 1'b0;
        sync_reset_n = 1'b1;
        tick();
        chk_eq("rst_stall_miss", miss_count, 1);
        chk_eq("rst_stall_fetch", fetch_count, 0);

        hold_out     = 1'b0;
        cache_rdline = 2'd3;
        for (int i = 0; i < 8; i++) begin
            cache_rdoffset = 3'(i);
            tick();
            chk_eq($sformatf("readback%0d", i), instr_out, 8'hC0 + 8'(i));
        end
        chk_eq("readback_fetch", fetch_count, 8);
        chk_eq("readback_miss", miss_count, 1);

        // Saturation: run fetches up to 0xFFFE, then three more
        repeat (16'hFFFE - 8) @(posedge clk);
        #1;
        chk_eq("sat_pre", fetch_count, 16'hFFFE);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_eq($sformatf("sat%0d", i), fetch_count, 16'hFFFF);
        end
        hold_out = 1'b1;
        tick();
        chk_eq("sat_stall_fetch", fetch_count, 16'hFFFF);
        chk_eq("sat_stall_miss", miss_count, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/icache_data_array.md
Name: icache_data_array

Overview:
- Data store and fetch register for the 4-line x 8-word direct-mapped instruction cache.
- Sits directly downstream of the program sequencer:
  - Accepts line-fill writes of ROM data driven by the sequencer's cache_wren/cache_wrline/cache_wroffset.
  - Serves reads addressed by cache_rdline/cache_rdoffset.
- Presents a registered instruction plus valid flag to the decoder.
- Keeps fetch and miss performance counters.

Parameters:
DATA_WIDTH, 8, instruction/ROM word width
LINE_BITS, 2, line index width (4 lines)
OFFSET_BITS, 3, word offset width (8 words per line)
CNT_WIDTH, 16, performance counter width

Ports:
clk  input  1  clock, all state updates on rising edge
sync_reset_n  input  1  synchronous reset, active-low
cache_wren  input  1  write ROM data into the array this cycle
cache_wrline  input  LINE_BITS  fill line index
cache_wroffset  input  OFFSET_BITS  fill word offset
rom_data  input  DATA_WIDTH  ROM word to be written
cache_rdline  input  LINE_BITS  fetch line index
cache_rdoffset  input  OFFSET_BITS  fetch word offset
hold_out  input  1  sequencer stall: fetch not accepted this cycle
instr_out  output  DATA_WIDTH  registered fetched instruction
instr_valid  output  1  instr_out holds a fresh instruction
fetch_count  output  CNT_WIDTH  accepted fetches, saturating
miss_count  output  CNT_WIDTH  stall episodes (misses), saturating

Behaviour:
Array and reset:
- Array is 2^LINE_BITS * 2^OFFSET_BITS words and is not reset. Contents are undefined until written.
- Writes occur regardless of sync_reset_n, so a fill overlapping reset is retained.
- Reset (sync_reset_n==0 at rising edge) sets:
  - instr_out = 0, instr_valid = 0
  - fetch_count = 0, miss_count = 0
  - internal hold_out_d = 0
- While reset is held, these stay at their reset values.

Write path:
- At the rising edge with cache_wren==1: mem[cache_wrline][cache_wroffset] <= rom_data.
- No write latency beyond that edge.

Read path, one-cycle latency, when not in reset:
- hold_out==0:
  - instr_out <= read data; instr_valid <= 1.
- hold_out==1:
  - instr_out holds its previous value; instr_valid <= 0 (bubble).
- Read data (write-through bypass):
  - If cache_wren==1 and cache_wrline==cache_rdline and cache_wroffset==cache_rdoffset in the same cycle, read data = rom_data.
  - Otherwise read data = mem[cache_rdline][cache_rdoffset], i.e. the pre-edge contents.
  - The bypass covers the sequencer's end-of-fill cycle: hold_out==0 while the last word is still being written.
- A write to a different address in the same cycle does not affect the read.

Counters, not in reset:
- hold_out_d <= hold_out every cycle.
- fetch_count increments by 1 on each edge where hold_out==0.
- miss_count increments by 1 on each edge where hold_out==1 and hold_out_d==0 (rising edge of stall).
- Both saturate at all-ones and never wrap. At saturation they hold until reset.
- Both may increment in the same cycle only if their conditions are both true. They are mutually exclusive by definition, so this never happens.

Arithmetic and width:
- Counters are unsigned CNT_WIDTH.
- Index concatenation is {line, offset}, no arithmetic on addresses.

Reset mid-stall:
- After reset releases, hold_out_d==0.
- If hold_out is already 1 on the first post-reset edge, that edge counts as a new miss.

Test Plan:
- Reset: drive sync_reset_n=0 for 2 cycles with hold_out=0 -> instr_out=0x00, instr_valid=0, fetch_count=0, miss_count=0; after release, first edge gives instr_valid=1 and fetch_count=1.
- Fill and read: write line 1 offsets 0..7 with 0x10..0x17 (hold_out=1 for the 8 cycles) -> miss_count=1, instr_valid=0 throughout; then read line1/offset5 with hold_out=0 -> next cycle instr_out=0x15, instr_valid=1.
- Bypass: same cycle cache_wren=1, wr=line2/off7, rom_data=0xA5, rd=line2/off7, hold_out=0 -> next cycle instr_out=0xA5; repeat with rd=line2/off6 holding 0x3C -> instr_out=0x3C, not 0xA5.
- Stall hold: instr_out=0x15 valid; assert hold_out for 3 cycles while changing read address -> instr_out stays 0x15, instr_valid=0 for 3 cycles, miss_count +1 only, fetch_count unchanged.
- Saturation: preload (via long run or force) fetch_count=0xFFFE; 3 accepted fetches -> 0xFFFF, 0xFFFF, 0xFFFF.
- Reset mid-fill: during an 8-word fill, assert sync_reset_n=0 at word 4 while wren continues -> outputs and counters cleared, words 0..7 still read back correctly afterwards; hold_out=1 on first post-reset edge -> miss_count=1.
